// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its address decoder.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   localparam int          NUM_SLV      = 4;
   localparam logic [19:0] SLV_BASE_DEF = 20'h1000_0;

   typedef logic [1:0] slv_idx_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps address bits [31:12] onto one of four 4 KiB completer windows starting at SLV_BASE.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter logic [19:0] SLV_BASE = SLV_BASE_DEF
)(
   input  logic [19:0]        addr_hi,
   output logic [NUM_SLV-1:0] sel,
   output logic               hit
);

   logic [19:0] offset;
   slv_idx_t    idx;

   // Wrapping subtraction folds addresses below the base into huge offsets, so one compare covers both ends.
   always_comb begin
      offset = addr_hi - SLV_BASE;
      idx    = slv_idx_t'(offset[1:0]);
      hit    = (offset < 20'(NUM_SLV));
      sel    = '0;
      if (hit)
         sel[idx] = 1'b1;
   end

endmodule

// File: rtl/apb_master.sv
// Single-beat APB initiator: CPU request -> SETUP/ACCESS on one of four completers -> one-cycle ready pulse.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter logic [19:0] SLV_BASE = SLV_BASE_DEF
`ifdef APB_TIMEOUT_EN
   ,parameter int         TIMEOUT  = 16
`endif
)(
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        error,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic [3:0]  PSEL,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3
);

   apb_state_t         state_q, state_n;
   logic [31:0]        paddr_n, pwdata_n, rdata_n;
   logic               pwrite_n, penable_n, ready_n, error_n;
   logic [NUM_SLV-1:0] psel_n;
   logic [NUM_SLV-1:0] dec_sel;
   logic               dec_hit;
   logic [NUM_SLV-1:0] pready_vec;
   logic [31:0]        prdata_vec [NUM_SLV];
   logic               pready_sel;
   logic [31:0]        prdata_sel;
`ifdef APB_TIMEOUT_EN
   localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);
   logic [4:0]         cnt_q, cnt_n;
`endif

   apb_addr_decoder #(.SLV_BASE(SLV_BASE)) u_dec (
      .addr_hi (addr[31:12]),
      .sel     (dec_sel),
      .hit     (dec_hit)
   );

   assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};
   assign prdata_vec[0] = PRDATA0;
   assign prdata_vec[1] = PRDATA1;
   assign prdata_vec[2] = PRDATA2;
   assign prdata_vec[3] = PRDATA3;

   // Only the currently selected completer may complete the access or supply data.
   always_comb begin
      pready_sel = 1'b0;
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (PSEL[i]) begin
            pready_sel = pready_sel | pready_vec[i];
            prdata_sel = prdata_sel | prdata_vec[i];
         end
      end
   end

   always_comb begin
      state_n   = state_q;
      paddr_n   = PADDR;
      pwdata_n  = PWDATA;
      pwrite_n  = PWRITE;
      psel_n    = PSEL;
      penable_n = PENABLE;
      rdata_n   = rdata;
      ready_n   = 1'b0;
      error_n   = 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_n     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (transfer) begin
               paddr_n  = addr;
               pwdata_n = wdata;
               pwrite_n = write;
               if (dec_hit) begin
                  psel_n    = dec_sel;
                  penable_n = 1'b0;
                  state_n   = SETUP;
               end else begin
                  ready_n = 1'b1;
                  error_n = 1'b1;
                  rdata_n = '0;
               end
            end
         end
         SETUP: begin
            penable_n = 1'b1;
            state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_n     = '0;
`endif
         end
         ACCESS: begin
            if (pready_sel) begin
               if (!PWRITE)
                  rdata_n = prdata_sel;
               ready_n   = 1'b1;
               psel_n    = '0;
               penable_n = 1'b0;
               state_n   = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               rdata_n   = '0;
               ready_n   = 1'b1;
               error_n   = 1'b1;
               psel_n    = '0;
               penable_n = 1'b0;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt_q + 5'd1;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         PSEL    <= '0;
         PENABLE <= 1'b0;
         rdata   <= '0;
         ready   <= 1'b0;
         error   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_n;
         PADDR   <= paddr_n;
         PWDATA  <= pwdata_n;
         PWRITE  <= pwrite_n;
         PSEL    <= psel_n;
         PENABLE <= penable_n;
         rdata   <= rdata_n;
         ready   <= ready_n;
         error   <= error_n;
`ifdef APB_TIMEOUT_EN
         cnt_q   <= cnt_n;
`endif
      end
   end

endmodule
